// File: rtl/parking_gate_ctrl_pkg.sv
// parking_pkg: shared state type, constants and fee helper for the parking gate controller
// Contents: gate_state_t FSM encoding, HOURS/FEE_WIDTH constants, slot_idx_t, fee_sat()
package parking_pkg;
    localparam int HOURS     = 24;
    localparam int FEE_WIDTH = 8;
    localparam int DEF_SLOTS = 8;

    typedef logic [$clog2(DEF_SLOTS)-1:0] slot_idx_t;

    typedef enum logic [2:0] {IDLE, SERVE_E, SERVE_X, ACK, GATE} gate_state_t;

    // Fee for a duration in hours at a given rate, clamped to the fee field maximum
    function automatic logic [FEE_WIDTH-1:0] fee_sat(input logic [31:0] dur, input logic [31:0] rate);
        logic [31:0] p;
        p = dur * rate;
        return p > 32'((1 << FEE_WIDTH) - 1) ? {FEE_WIDTH{1'b1}} : p[FEE_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/parking_gate_ctrl_if.sv
// parking_gate_ctrl_if: front-end/gate bundle between keypad/sensors, clock block and the controller
// master: drives lot_open, clock_time, entry_req, exit_req, exit_slot; observes everything else
// slave : the controller; drives clock_run, the four pulses, entry_slot, fee, gate_open, occupancy, full
interface parking_gate_ctrl_if
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS = 8
);
    localparam int SW = $clog2(NUM_SLOTS);

    logic                 lot_open;
    logic [11:0]          clock_time;
    logic                 clock_run;
    logic                 entry_req;
    logic                 exit_req;
    logic [SW-1:0]        exit_slot;
    logic                 entry_grant;
    logic                 entry_deny;
    logic [SW-1:0]        entry_slot;
    logic                 exit_grant;
    logic                 exit_err;
    logic [FEE_WIDTH-1:0] fee;
    logic                 gate_open;
    logic [SW:0]          occupancy;
    logic                 full;

    modport master (
        output lot_open, clock_time, entry_req, exit_req, exit_slot,
        input  clock_run, entry_grant, entry_deny, entry_slot, exit_grant, exit_err,
               fee, gate_open, occupancy, full
    );

    modport slave (
        input  lot_open, clock_time, entry_req, exit_req, exit_slot,
        output clock_run, entry_grant, entry_deny, entry_slot, exit_grant, exit_err,
               fee, gate_open, occupancy, full
    );
endinterface

// File: rtl/parking_gate_ctrl_slot_alloc.sv
// slot_alloc: lowest-index free slot finder over the occupied mask
// occ: occupied mask in; idx: lowest free slot out; found: at least one slot is free
module slot_alloc
    import parking_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]         occ,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);
    localparam int SW = $clog2(N);

    // Scanning downward lets the lowest free index overwrite any higher one
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                idx   = SW'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: arbitrates entry/exit requests onto one barrier gate, tracks slots and computes fees
// clk, rst_n (async, active low); bus (slave): lot_open, clock_time in; clock_run, entry/exit pulses,
// entry_slot, fee, gate_open, occupancy, full out
module parking_gate_ctrl #(
    parameter int NUM_SLOTS    = 8,
    parameter int HOURS        = parking_pkg::HOURS,
    parameter int FEE_PER_HOUR = 5,
    parameter int GATE_CYCLES  = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    parking_gate_ctrl_if.slave  bus
);
    import parking_pkg::*;

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int OW = SW + 1;
    localparam int CW = $clog2(GATE_CYCLES + 1);

    gate_state_t          state, nxt;
    logic                 rr_last, rr_nxt;  // 1 = exit side was served last
    logic [NUM_SLOTS-1:0] occ;
    logic [4:0]           stamp [NUM_SLOTS];
    logic [CW-1:0]        cnt;
    logic [SW-1:0]        free_idx;
    logic                 found;
    logic [4:0]           now, ent;
    logic [6:0]           dur;
    logic [FEE_WIDTH-1:0] fee_c, fee_q;
    logic [OW-1:0]        occ_cnt;
    logic                 clock_run_q, e_grant, e_deny, x_grant, x_err;
    logic [SW-1:0]        e_slot;
    logic                 unused_hi;

    slot_alloc #(.N(NUM_SLOTS)) u_alloc (.occ(occ), .idx(free_idx), .found(found));

    assign now       = bus.clock_time[4:0];
    assign ent       = stamp[bus.exit_slot];
    assign unused_hi = ^bus.clock_time[11:5];

    // Elapsed hours modulo the day; a same-hour stay counts as one started hour
    always_comb begin
        dur   = now >= ent ? 7'(now) - 7'(ent) : 7'(now) + 7'(HOURS) - 7'(ent);
        fee_c = fee_sat(32'(dur == '0 ? 7'd1 : dur), 32'(FEE_PER_HOUR));
    end

    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) occ_cnt = occ_cnt + OW'(occ[i]);
    end

    always_comb begin
        nxt    = state;
        rr_nxt = rr_last;
        case (state)
            IDLE: if (bus.lot_open && (bus.entry_req || bus.exit_req)) begin
                nxt    = (bus.entry_req && (!bus.exit_req || rr_last)) ? SERVE_E : SERVE_X;
                rr_nxt = nxt == SERVE_X;
            end
            SERVE_E, SERVE_X: nxt = ACK;
            ACK:     nxt = (e_grant || x_grant) ? GATE : IDLE;
            GATE:    nxt = cnt == CW'(GATE_CYCLES - 1) ? IDLE : GATE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_last <= 1'b1;
        end else begin
            state   <= nxt;
            rr_last <= rr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ         <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) stamp[i] <= '0;
            cnt         <= '0;
            clock_run_q <= 1'b0;
            e_grant     <= 1'b0;
            e_deny      <= 1'b0;
            x_grant     <= 1'b0;
            x_err       <= 1'b0;
            e_slot      <= '0;
            fee_q       <= '0;
        end else begin
            clock_run_q <= bus.lot_open;
            cnt         <= state == GATE ? cnt + 1'b1 : '0;
            e_grant     <= state == SERVE_E && found;
            e_deny      <= state == SERVE_E && !found;
            x_grant     <= state == SERVE_X && occ[bus.exit_slot];
            x_err       <= state == SERVE_X && !occ[bus.exit_slot];
            if (state == SERVE_E && found) begin
                occ[free_idx]   <= 1'b1;
                stamp[free_idx] <= now;
                e_slot          <= free_idx;
            end
            if (state == SERVE_X && occ[bus.exit_slot]) begin
                occ[bus.exit_slot] <= 1'b0;
                fee_q              <= fee_c;
            end
        end
    end

    assign bus.clock_run   = clock_run_q;
    assign bus.entry_grant = e_grant;
    assign bus.entry_deny  = e_deny;
    assign bus.entry_slot  = e_slot;
    assign bus.exit_grant  = x_grant;
    assign bus.exit_err    = x_err;
    assign bus.fee         = fee_q;
    assign bus.gate_open   = state == GATE;
    assign bus.occupancy   = occ_cnt;
    assign bus.full        = occ_cnt == OW'(NUM_SLOTS);
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: vector table, corner sequences and randomized ops against a slot/fee model
module tb_parking_gate_ctrl;
    import parking_pkg::*;

    localparam int GC   = 4;
    localparam int P_EG = 8;
    localparam int P_ED = 4;
    localparam int P_XG = 2;
    localparam int P_XE = 1;

    typedef struct {
        bit is_e;
        int slot;
        int hour;
        int code;
        int val;
        int occ;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    parking_gate_ctrl_if #(.NUM_SLOTS(8)) bus ();

    parking_gate_ctrl #(.NUM_SLOTS(8), .HOURS(24), .FEE_PER_HOUR(5), .GATE_CYCLES(GC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int pulses();
        return int'({bus.entry_grant, bus.entry_deny, bus.exit_grant, bus.exit_err});
    endfunction

    task automatic txn(input string nm, input bit is_e, input int slot, input logic [11:0] ct,
                       input int ecode, input int eval, input int eocc);
        int code, lat, gcnt, occ_s, full_s, slot_s, fee_s;
        @(negedge clk);
        bus.clock_time = ct;
        bus.entry_req  = is_e;
        bus.exit_req   = !is_e;
        bus.exit_slot  = 3'(slot);
        code = 0; lat = 0; occ_s = 0; full_s = 0; slot_s = 0; fee_s = 0;
        for (int i = 1; i <= 8 && code == 0; i++) begin
            @(negedge clk);
            code   = pulses();
            lat    = i;
            occ_s  = int'(bus.occupancy);
            full_s = int'(bus.full);
            slot_s = int'(bus.entry_slot);
            fee_s  = int'(bus.fee);
        end
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        gcnt = 0;
        repeat (GC + 3) begin
            @(negedge clk);
            gcnt += int'(bus.gate_open);
        end
        chk({nm, " pulse"}, code, ecode);
        chk({nm, " latency"}, lat, 2);
        if (ecode == P_EG) chk({nm, " entry_slot"}, slot_s, eval);
        if (ecode == P_XG) chk({nm, " fee"}, fee_s, eval);
        chk({nm, " occupancy"}, occ_s, eocc);
        chk({nm, " full"}, full_s, int'(eocc == 8));
        chk({nm, " gate_cycles"}, gcnt, (ecode == P_EG || ecode == P_XG) ? GC : 0);
    endtask

    // Both requests raised together; each side drops its request when its own pulse arrives
    task automatic rr_pair(input int hour, output int first, output int second, output int xfee);
        int p;
        @(negedge clk);
        bus.clock_time = 12'(hour);
        bus.exit_slot  = 3'd3;
        bus.entry_req  = 1'b1;
        bus.exit_req   = 1'b1;
        first = 0; second = 0; xfee = -1;
        for (int i = 0; i < 40 && second == 0; i++) begin
            @(negedge clk);
            p = pulses();
            if (p != 0) begin
                if (first == 0) first = p;
                else second = p;
                if (p == P_XG) xfee = int'(bus.fee);
                if (p == P_EG || p == P_ED) bus.entry_req = 1'b0;
                else bus.exit_req = 1'b0;
            end
        end
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        repeat (GC + 3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [18];
        bit   m_occ [8];
        int   m_stamp [8];
        int   a, b, f, p, gseen, code, val, idx, d, eocc, hour, slot;
        bit   is_e;

        tbl[0] = '{1, 0, 3,  P_EG, 0,  1};
        tbl[1] = '{0, 0, 7,  P_XG, 20, 0};
        tbl[2] = '{1, 0, 22, P_EG, 0,  1};
        tbl[3] = '{0, 0, 1,  P_XG, 15, 0};
        tbl[4] = '{1, 0, 10, P_EG, 0,  1};
        tbl[5] = '{0, 0, 10, P_XG, 5,  0};
        tbl[6] = '{0, 6, 4,  P_XE, 0,  0};
        for (int i = 0; i < 8; i++) tbl[7 + i] = '{1, 0, 2, P_EG, i, i + 1};
        tbl[15] = '{1, 0, 5, P_ED, 0,  8};
        tbl[16] = '{0, 5, 9, P_XG, 35, 7};
        tbl[17] = '{1, 0, 9, P_EG, 5,  8};

        bus.lot_open = 1'b0; bus.clock_time = '0; bus.entry_req = 1'b0;
        bus.exit_req = 1'b0; bus.exit_slot = '0;
        repeat (2) @(negedge clk);
        chk("reset clock_run", int'(bus.clock_run), 0);
        chk("reset gate_open", int'(bus.gate_open), 0);
        chk("reset occupancy", int'(bus.occupancy), 0);
        chk("reset full", int'(bus.full), 0);
        chk("reset pulses", pulses(), 0);
        chk("reset entry_slot", int'(bus.entry_slot), 0);
        chk("reset fee", int'(bus.fee), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("clock_run while closed", int'(bus.clock_run), 0);
        bus.lot_open = 1'b1;
        @(negedge clk);
        chk("clock_run after open", int'(bus.clock_run), 1);

        for (int k = 0; k < 18; k++)
            txn($sformatf("vec%0d", k), tbl[k].is_e, tbl[k].slot, 12'(tbl[k].hour),
                tbl[k].code, tbl[k].val, tbl[k].occ);

        // Last served was an entry, so simultaneous requests start on the exit side
        rr_pair(12, a, b, f);
        chk("rr1 first", a, P_XG);
        chk("rr1 second", b, P_EG);
        chk("rr1 fee", f, 50);
        rr_pair(12, a, b, f);
        chk("rr2 first", a, P_XG);
        chk("rr2 second", b, P_EG);
        chk("rr2 fee", f, 5);

        @(negedge clk);
        bus.lot_open  = 1'b0;
        bus.entry_req = 1'b1;
        p = 0;
        repeat (6) begin
            @(negedge clk);
            p |= pulses();
        end
        chk("closed lot pulses", p, 0);
        chk("closed lot clock_run", int'(bus.clock_run), 0);
        chk("closed lot occupancy", int'(bus.occupancy), 8);
        bus.entry_req = 1'b0;
        bus.lot_open  = 1'b1;
        @(negedge clk);

        bus.clock_time = 12'd15;
        bus.exit_slot  = 3'd0;
        bus.exit_req   = 1'b1;
        gseen = 0;
        for (int i = 0; i < 10 && gseen == 0; i++) begin
            @(negedge clk);
            if (pulses() != 0) bus.exit_req = 1'b0;
            gseen = int'(bus.gate_open);
        end
        bus.exit_req = 1'b0;
        chk("pre-reset gate_open", gseen, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset gate_open", int'(bus.gate_open), 0);
        chk("async reset occupancy", int'(bus.occupancy), 0);
        chk("async reset full", int'(bus.full), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (m_occ[i]) begin
            m_occ[i]   = 1'b0;
            m_stamp[i] = 0;
        end
        for (int n = 0; n < 80; n++) begin
            is_e = $urandom_range(0, 9) < 6;
            slot = $urandom_range(0, 7);
            hour = $urandom_range(0, 23);
            val  = 0;
            if (is_e) begin
                idx = -1;
                for (int i = 7; i >= 0; i--) if (!m_occ[i]) idx = i;
                if (idx < 0) code = P_ED;
                else begin
                    code = P_EG;
                    val  = idx;
                    m_occ[idx]   = 1'b1;
                    m_stamp[idx] = hour;
                end
            end else if (!m_occ[slot]) code = P_XE;
            else begin
                d = (hour - m_stamp[slot] + 24) % 24;
                if (d == 0) d = 1;
                val  = d * 5 > 255 ? 255 : d * 5;
                code = P_XG;
                m_occ[slot] = 1'b0;
            end
            eocc = 0;
            foreach (m_occ[i]) eocc += int'(m_occ[i]);
            txn($sformatf("rnd%0d", n), is_e, slot, {7'($urandom), 5'(hour)}, code, val, eocc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Controller for the shared barrier gate and the hour-of-day clock in the parking lot.
- Drives the clock's run enable, and arbitrates entry and exit requests onto one gate.
- On entry: allocates a slot and stamps the entry hour. On exit: frees the slot and computes the fee from the elapsed hours.
- Sits between the keypad/sensor front end and the gate actuator; it consumes the 12-bit hour count produced by the clock block.

Parameters:
- NUM_SLOTS, 8, number of parking slots (power of two, 2..16).
- HOURS, 24, modulus of the hour count.
- FEE_PER_HOUR, 5, fee units charged per started hour.
- GATE_CYCLES, 4, cycles gate_open is held per granted transaction (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- lot_open  in  1  lot enable; requests accepted only while high.
- clock_time  in  12  current hour from the clock block; only bits [4:0] are used.
- clock_run  out  1  run enable to the clock block (its active-low start).
- entry_req  in  1  entry request, held until entry_grant or entry_deny.
- exit_req  in  1  exit request, held until exit_grant or exit_err.
- exit_slot  in  $clog2(NUM_SLOTS)  slot being vacated; stable while exit_req is high.
- entry_grant  out  1  one-cycle pulse: entry accepted.
- entry_deny  out  1  one-cycle pulse: lot full.
- entry_slot  out  $clog2(NUM_SLOTS)  allocated slot; valid with entry_grant.
- exit_grant  out  1  one-cycle pulse: exit accepted.
- exit_err  out  1  one-cycle pulse: exit_slot was not occupied.
- fee  out  8  fee for the exit; valid with exit_grant.
- gate_open  out  1  barrier open.
- occupancy  out  $clog2(NUM_SLOTS)+1  number of occupied slots.
- full  out  1  occupancy == NUM_SLOTS.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state IDLE, occupied mask 0, entry-hour table 0, rr_last = exit.
  - All outputs 0: clock_run, pulses, entry_slot, fee, gate_open, occupancy, full.
- clock_run is lot_open registered (1-cycle delay). While lot_open is low the clock block holds hour 0; occupancy and stamps are retained.
- FSM states: IDLE, SERVE_E, SERVE_X, ACK, GATE.
  - IDLE, lot_open low or no request: stay IDLE.
  - IDLE, exactly one request pending: go to SERVE_E or SERVE_X.
  - IDLE, both requests pending: round-robin; serve the side not served last, then update rr_last.
  - SERVE_E, full: register entry_deny, go to ACK.
  - SERVE_E, not full: pick the lowest-index free slot, set its occupied bit, store clock_time[4:0] as its entry hour, register entry_slot, go to ACK.
  - SERVE_X, slot not occupied: register exit_err, go to ACK.
  - SERVE_X, slot occupied: clear its bit, register fee, go to ACK.
  - ACK: exactly one pulse is high for one cycle. Next state is GATE if granted, IDLE if denied or error.
  - GATE: gate_open high for exactly GATE_CYCLES cycles, then IDLE.
- Latency: request sampled in IDLE at cycle 0 → pulse visible at cycle 2 → gate_open cycles 3..3+GATE_CYCLES-1.
- Requester must drop req by the cycle after ACK. A req still high when IDLE is re-entered is treated as a new request.
- Fee arithmetic:
  - now = clock_time[4:0], ent = stored hour.
  - dur = now - ent if now >= ent, else now + HOURS - ent.
  - dur == 0 is charged as 1.
  - fee = dur * FEE_PER_HOUR, saturated at 255.
  - Wrap-around midnight is handled by the modulus; stays beyond HOURS alias, which is accepted.
- occupancy and full update in the cycle after SERVE_E/SERVE_X, i.e. together with the ACK pulse.
- Withdrawn request (req falls during SERVE_*): the transaction still completes and the pulse is still issued.
- lot_open falling mid-transaction: the current transaction completes; new requests are ignored.
- Asynchronous reset mid-operation: immediate return to reset values; gate_open drops without completing its count.

Decomposition:
- Shared package parking_pkg:
  - state enum gate_state_t.
  - constants HOURS and FEE_WIDTH = 8.
  - slot index typedef slot_idx_t sized by NUM_SLOTS (default 8 → 3 bits).
  - fee saturation function.
- One sub-module: slot_alloc.
  - Combinational lowest-free-slot priority encoder plus found flag, over the occupied mask.

Test Plan:
- Reset then lot_open=1 → clock_run=1 the next cycle; occupancy=0, full=0, gate_open=0.
- entry_req at hour 3 → entry_grant with entry_slot=0 at cycle 2; gate_open for 4 cycles; occupancy=1. exit_req slot 0 at hour 7 → exit_grant, fee=20.
- Entry at hour 22, exit at hour 1 → fee=15 (3 h across midnight). Entry and exit in the same hour → fee=5.
- Fill 8 slots, then a 9th entry_req → entry_deny, gate_open stays 0, full=1. Exit slot 5, then entry → entry_slot=5.
- entry_req and exit_req raised in the same cycle twice in succession → served in order exit, entry, then exit, entry (round-robin alternates, starting with entry after reset).
- exit_req for an unoccupied slot 6 → exit_err, no gate, occupancy unchanged. rst_n low during GATE → gate_open=0 immediately.
